// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM serving core load/store requests, zero-filled after reset.
// Latency: a request accepted at edge N has its response registered at that same edge (visible from cycle N+1).
// Backpressure: one response slot; req_ready drops while a response is held with rsp_ready low, and during the init sweep.
module data_mem_responder #(
  parameter int DATA_W    = 22,
  parameter int ADDR_W    = 22,
  parameter int DEPTH     = 256,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WIDX_W = ADDR_W - 2;
  localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  sweep_idx, sweep_idx_nxt;
  logic              sweep_we;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [WIDX_W-1:0] word_idx;
  logic [IDX_W-1:0]  ram_idx;
  logic              addr_err;
  logic              accept;
  logic              do_store;
  logic              do_load;

  // Address decode: the full word index is range-checked so out-of-range addresses never alias into the RAM.
  assign word_idx = req_addr[ADDR_W-1:2];
  assign ram_idx  = word_idx[IDX_W-1:0];
  assign addr_err = (req_addr[1:0] != 2'b00) || (word_idx >= DEPTH_LIM);
  assign accept   = req_valid && req_ready;
  assign do_store = accept && req_write && !addr_err;
  assign do_load  = accept && !req_write && !addr_err;

  // State register and sweep index; reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
      sweep_idx <= '0;
    end else begin
      state     <= state_nxt;
      sweep_idx <= sweep_idx_nxt;
    end
  end

  // Next-state logic: sweep one word per cycle, then serve requests forever.
  always_comb begin
    state_nxt     = state;
    sweep_idx_nxt = sweep_idx;
    sweep_we      = 1'b0;
    busy          = 1'b0;
    req_ready     = 1'b0;
    case (state)
      ST_INIT: begin
        busy     = 1'b1;
        sweep_we = 1'b1;
        if (sweep_idx == IDX_LAST) begin
          state_nxt = ST_READY;
        end else begin
          sweep_idx_nxt = sweep_idx + IDX_W'(1);
        end
      end
      ST_READY: begin
        req_ready = !rsp_valid || rsp_ready;
      end
      default: begin
        state_nxt = ST_READY;
      end
    endcase
  end

  // RAM write port: sweep zero-fill or accepted in-range store; reset itself never writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_we) begin
        mem[sweep_idx] <= '0;
      end else if (do_store) begin
        mem[ram_idx] <= req_wdata;
      end
    end
  end

  // Response register: loads on accept (old RAM word for loads), holds while stalled, frees on consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= addr_err;
      rsp_rdata <= do_load ? mem[ram_idx] : '0;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
